// File: rtl/op_arbiter.sv
// op_arbiter: round-robin arbiter that hands the shared add/shr units to one
// requester at a time, steers that requester's operands onto the shared
// operand buses, and forces a release if the owner never reports done.
module op_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      done_in,
  output logic [NREQ-1:0]      start_out,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic [16*NREQ-1:0]   add_a_req,
  input  logic [16*NREQ-1:0]   add_b_req,
  input  logic [16*NREQ-1:0]   shr_a_req,
  input  logic [16*NREQ-1:0]   shr_b_req,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  output logic [15:0]          shr_a,
  output logic [15:0]          shr_b,
  input  logic [15:0]          add_in,
  input  logic [15:0]          shr_in
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [OW-1:0]   last_owner;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   idx;
  logic [NREQ-1:0] win_onehot;
  logic            win_valid;
  logic [9:0]      wdog;
  logic            owner_done;
  logic            wdog_expire;
  logic            unused_results;

  // The unit results go straight back to the requesters outside this block.
  assign unused_results = ^{add_in, shr_in};

  // Only the current owner's done pulse counts; other bits are ignored.
  assign owner_done  = |(done_in & grant);
  assign wdog_expire = (wdog == 10'(TIMEOUT - 1));

  // Round-robin pick: scan from the requester after the last owner.
  always_comb begin
    win_valid  = 1'b0;
    win_onehot = '0;
    idx        = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = OW'((int'(last_owner) + 1 + i) % NREQ);
      if (!win_valid && req[idx]) begin
        win_valid       = 1'b1;
        win_onehot[idx] = 1'b1;
      end
    end
  end

  // Encode the one-hot grant into an index for the round-robin pointer.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) owner = OW'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; RELEASE always returns to IDLE to force a gap between owners.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_valid) state_next = START;
      START:   state_next = BUSY;
      BUSY:    if (owner_done || wdog_expire) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, watchdog, timeout pulse and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
      last_owner  <= OW'(NREQ - 1);
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) grant <= win_onehot;
        end
        START: begin
          wdog <= '0;
        end
        BUSY: begin
          if (!owner_done) begin
            if (wdog != 10'(TIMEOUT)) wdog <= wdog + 10'd1;
            if (wdog_expire) timeout_err <= 1'b1;
          end
        end
        RELEASE: begin
          last_owner <= owner;
          grant      <= '0;
        end
        default: ;
      endcase
    end
  end

  // Start pulse lasts exactly the START cycle; busy follows the held grant.
  always_comb begin
    start_out = (state == START) ? grant : '0;
    busy      = |grant;
  end

  // Operand mux driven from the registered one-hot grant; all zero when idle.
  always_comb begin
    add_a = '0;
    add_b = '0;
    shr_a = '0;
    shr_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        add_a = add_a | add_a_req[16*k +: 16];
        add_b = add_b | add_b_req[16*k +: 16];
        shr_a = shr_a | shr_a_req[16*k +: 16];
        shr_b = shr_b | shr_b_req[16*k +: 16];
      end
    end
  end

endmodule

// File: tb/tb_op_arbiter.sv
// tb_op_arbiter: directed-vector bench for op_arbiter with hand-computed expectations.
module tb_op_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  done_in;
  logic [3:0]  start_out;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;
  logic [63:0] add_a_req;
  logic [63:0] add_b_req;
  logic [63:0] shr_a_req;
  logic [63:0] shr_b_req;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] shr_a;
  logic [15:0] shr_b;
  logic [15:0] add_in;
  logic [15:0] shr_in;

  int vectors;
  int miscompares;
  logic early_timeout;
  logic [3:0] rr_order [5];

  op_arbiter #(.NREQ(4), .TIMEOUT(1023)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done_in     (done_in),
    .start_out   (start_out),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .add_a_req   (add_a_req),
    .add_b_req   (add_b_req),
    .shr_a_req   (shr_a_req),
    .shr_b_req   (shr_b_req),
    .add_a       (add_a),
    .add_b       (add_b),
    .shr_a       (shr_a),
    .shr_b       (shr_b),
    .add_in      (add_in),
    .shr_in      (shr_in)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    req     = r;
    done_in = d;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    add_in      = 16'hdead;
    shr_in      = 16'hbeef;
    add_a_req   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    add_b_req   = {16'hb444, 16'hb333, 16'hb222, 16'hb111};
    shr_a_req   = {16'hc444, 16'hc333, 16'hc222, 16'hc111};
    shr_b_req   = {16'hd444, 16'hd333, 16'hd222, 16'hd111};
    applyStimulus(4'b0000, 4'b0000);
    #2;
    checkOutput("reset_grant", {60'd0, grant}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_start", {60'd0, start_out}, 64'd0);
    checkOutput("reset_timeout", {63'd0, timeout_err}, 64'd0);
    checkOutput("reset_add_a", {48'd0, add_a}, 64'd0);
    step();
    reset = 1'b1;
    step();
    checkOutput("idle_grant", {60'd0, grant}, 64'd0);
    checkOutput("idle_ops", {add_a, add_b, shr_a, shr_b}, 64'd0);

    // Single request from requester 0.
    applyStimulus(4'b0001, 4'b0000);
    step();
    checkOutput("single_grant", {60'd0, grant}, 64'h1);
    checkOutput("single_start", {60'd0, start_out}, 64'h1);
    checkOutput("single_busy", {63'd0, busy}, 64'h1);
    checkOutput("single_ops", {add_a, add_b, shr_a, shr_b}, 64'h1111_b111_c111_d111);
    step();
    checkOutput("single_start_gone", {60'd0, start_out}, 64'h0);
    checkOutput("single_hold", {60'd0, grant}, 64'h1);
    applyStimulus(4'b0001, 4'b0001);
    step();
    checkOutput("single_release_cycle", {60'd0, grant}, 64'h1);
    applyStimulus(4'b0000, 4'b0000);
    step();
    checkOutput("single_released", {60'd0, grant}, 64'h0);
    checkOutput("single_not_busy", {63'd0, busy}, 64'h0);

    // All requesting: round robin continues from requester 0.
    rr_order[0] = 4'b0010;
    rr_order[1] = 4'b0100;
    rr_order[2] = 4'b1000;
    rr_order[3] = 4'b0001;
    rr_order[4] = 4'b0010;
    applyStimulus(4'b1111, 4'b0000);
    for (int n = 0; n < 5; n++) begin
      step();
      checkOutput($sformatf("rr%0d_grant", n), {60'd0, grant}, {60'd0, rr_order[n]});
      checkOutput($sformatf("rr%0d_start", n), {60'd0, start_out}, {60'd0, rr_order[n]});
      step();
      if (n == 0) begin
        applyStimulus(4'b1111, 4'b0100);
        step();
        applyStimulus(4'b1101, 4'b0000);
        step();
        checkOutput("foreign_done_hold", {60'd0, grant}, 64'h2);
        checkOutput("drop_req_hold", {60'd0, grant}, 64'h2);
        applyStimulus(4'b1111, 4'b0000);
      end
      if (n == 1) begin
        checkOutput("rr_owner2_add_a", {48'd0, add_a}, 64'h3333);
        checkOutput("rr_owner2_shr_b", {48'd0, shr_b}, 64'hd333);
      end
      applyStimulus(4'b1111, rr_order[n]);
      step();
      checkOutput($sformatf("rr%0d_release", n), {60'd0, grant}, {60'd0, rr_order[n]});
      applyStimulus(4'b1111, 4'b0000);
      step();
      checkOutput($sformatf("rr%0d_idle", n), {60'd0, grant}, 64'h0);
    end

    // Watchdog: last owner was 1, so requester 0 wins; never signal done.
    applyStimulus(4'b0001, 4'b0000);
    step();
    checkOutput("wd_grant", {60'd0, grant}, 64'h1);
    early_timeout = 1'b0;
    for (int c = 0; c < 1023; c++) begin
      step();
      if (timeout_err !== 1'b0 || grant !== 4'b0001) early_timeout = 1'b1;
    end
    checkOutput("wd_no_early", {63'd0, early_timeout}, 64'h0);
    step();
    checkOutput("wd_timeout_pulse", {63'd0, timeout_err}, 64'h1);
    checkOutput("wd_grant_held", {60'd0, grant}, 64'h1);
    applyStimulus(4'b0000, 4'b0000);
    step();
    checkOutput("wd_released", {60'd0, grant}, 64'h0);
    checkOutput("wd_pulse_over", {63'd0, timeout_err}, 64'h0);

    // Reset while requester 2 owns the units.
    applyStimulus(4'b0100, 4'b0000);
    step();
    checkOutput("rst_busy_grant", {60'd0, grant}, 64'h4);
    step();
    reset = 1'b0;
    #1;
    checkOutput("rst_async_grant", {60'd0, grant}, 64'h0);
    checkOutput("rst_async_ops", {add_a, add_b, shr_a, shr_b}, 64'h0);
    checkOutput("rst_async_busy", {63'd0, busy}, 64'h0);
    checkOutput("rst_async_timeout", {63'd0, timeout_err}, 64'h0);
    step();
    reset = 1'b1;
    applyStimulus(4'b1111, 4'b0000);
    step();
    checkOutput("post_rst_grant", {60'd0, grant}, 64'h1);
    checkOutput("post_rst_start", {60'd0, start_out}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
